// File: rtl/core_pkg.sv
// Shared core definitions.
//   XLEN              : datapath width
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   IMEM_BASE_DEFAULT : default byte address of imem word 0
//   ifetch_state_t    : fetch FSM states
package core_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h8000_0000;
   localparam logic [XLEN-1:0] IMEM_BASE_DEFAULT = 32'h8000_0000;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } ifetch_state_t;

endpackage

// File: rtl/ifetch.sv
// Instruction fetch stage. Owns the PC, drives a synchronous-read imem and presents
// one PC/instruction pair per cycle to decode over a valid/ready handshake.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   imem_addr       : byte address to imem (registered inside imem)
//   imem_data       : imem word for the address presented last cycle
//   redirect_valid  : execute requests a PC change this cycle
//   redirect_pc     : redirect target (low two bits ignored)
//   out_valid/ready : handshake toward decode
//   out_pc          : PC of the presented instruction
//   out_instr       : presented instruction word
//   out_fault       : out_pc lies outside the populated imem window
module ifetch
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter logic [XLEN-1:0] IMEM_BASE  = IMEM_BASE_DEFAULT,
   parameter int unsigned     IMEM_WORDS = 256
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_instr,
   output logic            out_fault
);

   // Window bounds in 33 bits so base + size cannot wrap.
   localparam logic [XLEN:0] IMEM_LO = {1'b0, IMEM_BASE};
   localparam logic [XLEN:0] IMEM_HI = IMEM_LO + ({1'b0, 32'(IMEM_WORDS)} << 2);

   function automatic logic out_of_range(input logic [XLEN-1:0] addr);
      logic [XLEN:0] wide;
      wide = {1'b0, addr};
      return (wide < IMEM_LO) || (wide >= IMEM_HI);
   endfunction

   ifetch_state_t   state, state_next;
   logic [XLEN-1:0] resp_pc;
   logic            resp_fault;

   // Fetch address and next state.
   always_comb begin
      imem_addr  = RESET_PC;
      state_next = RUN;
      if (rst) begin
         imem_addr = RESET_PC;
      end else if (redirect_valid) begin
         imem_addr = redirect_pc & ~32'h0000_0003;
      end else if (state == BOOT) begin
         imem_addr = RESET_PC;
      end else if (!out_ready) begin
         // Re-read the same word so imem_data stays stable under back-pressure.
         imem_addr = resp_pc;
      end else begin
         imem_addr = resp_pc + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BOOT;
         resp_pc    <= RESET_PC;
         resp_fault <= 1'b0;
      end else begin
         state      <= state_next;
         resp_pc    <= imem_addr;
         resp_fault <= out_of_range(imem_addr);
      end
   end

   // A redirect kills the word currently in flight.
   assign out_valid = (state == RUN) && !redirect_valid;
   assign out_pc    = resp_pc;
   assign out_fault = resp_fault;
   assign out_instr = imem_data;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch with a behavioural synchronous-read imem model.
module tb_ifetch;

   localparam logic [31:0] BAD_WORD = 32'hBAD0_BAD0;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_fault;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   ifetch dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_fault      (out_fault)
   );

   // imem model: word i holds 0xC0DE_0000 | i; address registered on clk.
   logic [31:0] mem [256];
   logic [31:0] mem_addr_q;
   logic [31:0] mem_off;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
   end

   always @(posedge clk) mem_addr_q <= imem_addr;

   always_comb begin
      mem_off   = mem_addr_q - 32'h8000_0000;
      imem_data = BAD_WORD;
      if (mem_off < 32'd1024) imem_data = mem[mem_off[9:2]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
      exp_t e;
      e.pc    = pc;
      e.instr = instr;
      e.fault = fault;
      exp_q.push_back(e);
   endtask

   // Start a new cycle: drive inputs just after the rising edge.
   task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
      @(posedge clk);
      #1;
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Monitor: every handshake pops and checks one expected response.
   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_xfer: got pc %h, expected no transfer", out_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("xfer_pc", out_pc, e.pc);
            check("xfer_fault", {31'b0, out_fault}, {31'b0, e.fault});
            if (!e.fault) check("xfer_instr", out_instr, e.instr);
         end
      end
   end

   // Watchdog.
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic boot_checks(input string tag);
      check({tag, "_boot_valid"}, {31'b0, out_valid}, 32'd0);
      check({tag, "_boot_pc"}, out_pc, 32'h8000_0000);
      check({tag, "_boot_fault"}, {31'b0, out_fault}, 32'd0);
      check({tag, "_boot_addr"}, imem_addr, 32'h8000_0000);
   endtask

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b1;
      sample();
      check("rst_addr", imem_addr, 32'h8000_0000);

      // Reset release with ready held high.
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      push(32'h8000_0000, 32'hC0DE_0000, 1'b0);
      push(32'h8000_0004, 32'hC0DE_0001, 1'b0);
      push(32'h8000_0008, 32'hC0DE_0002, 1'b0);
      sample();
      boot_checks("r1");
      cyc(1'b0, 1'b0, 32'h0, 1'b1); sample();   // pc 0
      cyc(1'b0, 1'b0, 32'h0, 1'b1); sample();   // pc 4

      // Stall three cycles on pc 8.
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 32'h0, 1'b0);
         sample();
         check("stall_valid", {31'b0, out_valid}, 32'd1);
         check("stall_pc", out_pc, 32'h8000_0008);
         check("stall_instr", out_instr, 32'hC0DE_0002);
         check("stall_addr", imem_addr, 32'h8000_0008);
      end
      cyc(1'b0, 1'b0, 32'h0, 1'b1);              // pc 8 accepted
      push(32'h8000_000C, 32'hC0DE_0003, 1'b0);
      sample();
      check("release_addr", imem_addr, 32'h8000_000C);
      cyc(1'b0, 1'b0, 32'h0, 1'b1); sample();    // pc C

      // Redirect with ready high; in-flight pc 0x10 is killed.
      cyc(1'b0, 1'b1, 32'h8000_0043, 1'b1);
      sample();
      check("redir_addr", imem_addr, 32'h8000_0040);
      check("redir_valid", {31'b0, out_valid}, 32'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      push(32'h8000_0040, 32'hC0DE_0010, 1'b0);
      sample();

      // Redirect while stalled on pc 0x44.
      cyc(1'b0, 1'b1, 32'h8000_0100, 1'b0);
      sample();
      check("stall_redir_valid", {31'b0, out_valid}, 32'd0);
      check("stall_redir_addr", imem_addr, 32'h8000_0100);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      sample();
      check("stall_redir_pc", out_pc, 32'h8000_0100);
      check("stall_redir_instr", out_instr, 32'hC0DE_0040);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      push(32'h8000_0100, 32'hC0DE_0040, 1'b0);
      sample();

      // Range faults: last populated word, then one past the end.
      cyc(1'b0, 1'b1, 32'h8000_03FC, 1'b1); sample();
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      push(32'h8000_03FC, 32'hC0DE_00FF, 1'b0);
      sample();
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      push(32'h8000_0400, 32'h0, 1'b1);
      sample();
      // Redirect below the window.
      cyc(1'b0, 1'b1, 32'h0000_0000, 1'b1); sample();
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      push(32'h0000_0000, 32'h0, 1'b1);
      sample();
      // Redirect to the top of the address space; next PC wraps to 0.
      cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1); sample();
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      push(32'hFFFF_FFFC, 32'h0, 1'b1);
      sample();
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      push(32'h0000_0000, 32'h0, 1'b1);
      sample();
      check("wrap_next_addr", imem_addr, 32'h0000_0004);

      // Mid-run reset: pc 4 is still transferred in the reset cycle.
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      push(32'h0000_0004, 32'h0, 1'b1);
      sample();
      check("midrst_addr", imem_addr, 32'h8000_0000);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      push(32'h8000_0000, 32'hC0DE_0000, 1'b0);
      push(32'h8000_0004, 32'hC0DE_0001, 1'b0);
      push(32'h8000_0008, 32'hC0DE_0002, 1'b0);
      sample();
      boot_checks("r2");
      cyc(1'b0, 1'b0, 32'h0, 1'b1); sample();
      cyc(1'b0, 1'b0, 32'h0, 1'b1); sample();
      cyc(1'b0, 1'b0, 32'h0, 1'b1); sample();

      // Drain: no further transfers, every expected response consumed.
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      sample();
      check("leftover_expected", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
